// File: rtl/sb_cfg_pkg.sv
// Shared types and helpers for the switch-block configuration bank.
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Bit offset of word idx inside a flattened bus of sel_w-bit words.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned sel_w);
        return idx * sel_w;
    endfunction

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_mux);
        return addr < num_mux;
    endfunction

endpackage

// File: rtl/sb_cfg_word.sv
// One mux select word: shadow register written by the programming port,
// active register (plus registered inverse) loaded from shadow on commit.
module sb_cfg_word #(
    parameter int unsigned SEL_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wdata,
    input  logic             commit_en,
    output logic [SEL_W-1:0] shadow_q,
    output logic [SEL_W-1:0] active_q,
    output logic [SEL_W-1:0] active_qb
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (wr_en) begin
            shadow_q <= wdata;
        end
    end

    // True and inverted copies load together so the fabric never sees a mixed pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            active_qb <= '1;
        end else if (commit_en) begin
            active_q  <= shadow_q;
            active_qb <= ~shadow_q;
        end
    end

endmodule

// File: rtl/sb_cfg_bank.sv
// Switch-block routing configuration bank: shadow/active select words with
// a valid/ready programming port, read-back and atomic shadow-to-active commit.
module sb_cfg_bank
    import sb_cfg_pkg::*;
#(
    parameter int unsigned NUM_MUX = 24,
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                     prog_clk,
    input  logic                     prog_reset_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [SEL_W-1:0]         cfg_wdata,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [SEL_W-1:0]         rd_data,
    input  logic                     commit,
    output logic                     commit_done,
    input  logic                     lock,
    output logic                     err,
    output logic [NUM_MUX*SEL_W-1:0] sram,
    output logic [NUM_MUX*SEL_W-1:0] sram_inv
);

    state_t             state_q, state_d;
    logic               ready_en_q;
    logic               rd_valid_d, commit_done_d, err_d;
    logic [SEL_W-1:0]   rd_data_d;
    logic               wr_hit, commit_en, addr_ok;
    logic [NUM_MUX-1:0] addr_dec;
    logic [SEL_W-1:0]   shadow_w [NUM_MUX];
    logic [SEL_W-1:0]   rd_or    [NUM_MUX+1];

    assign addr_ok  = addr_in_range(32'(cfg_addr), NUM_MUX);
    assign rd_or[0] = '0;

    // Per-word decode, storage and an OR-chain read mux.
    for (genvar g = 0; g < NUM_MUX; g++) begin : g_word
        localparam int unsigned LO = slice_lo(g, SEL_W);

        assign addr_dec[g] = (cfg_addr == ADDR_W'(g));
        assign rd_or[g+1]  = rd_or[g] | (addr_dec[g] ? shadow_w[g] : '0);

        sb_cfg_word #(.SEL_W(SEL_W)) u_word (
            .clk       (prog_clk),
            .rst_n     (prog_reset_n),
            .wr_en     (wr_hit && addr_dec[g]),
            .wdata     (cfg_wdata),
            .commit_en (commit_en),
            .shadow_q  (shadow_w[g]),
            .active_q  (sram[LO +: SEL_W]),
            .active_qb (sram_inv[LO +: SEL_W])
        );
    end

    // ready_en_q holds off the port until the first edge after reset release.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= ST_IDLE;
            ready_en_q  <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            commit_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            rd_valid    <= rd_valid_d;
            rd_data     <= rd_data_d;
            commit_done <= commit_done_d;
            err         <= err_d;
        end
    end

    // Commit outranks a pending request; rejected operations only raise err.
    always_comb begin
        state_d       = state_q;
        rd_valid_d    = rd_valid;
        rd_data_d     = rd_data;
        commit_done_d = 1'b0;
        err_d         = 1'b0;
        wr_hit        = 1'b0;
        commit_en     = 1'b0;
        cfg_ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready = ready_en_q && !commit;
                if (commit) begin
                    if (lock) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else if (cfg_valid && cfg_ready) begin
                    if (cfg_we) begin
                        if (addr_ok && !lock) begin
                            wr_hit = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        rd_data_d  = addr_ok ? rd_or[NUM_MUX] : '0;
                        err_d      = !addr_ok;
                        rd_valid_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                commit_en     = 1'b1;
                commit_done_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
